// File: rtl/spi_flash_responder_pkg.sv
// rtl/spi_flash_responder_pkg.sv - shared states, opcode and byte helpers for the SPI flash responder
package spi_flash_responder_pkg;

  typedef enum logic [2:0] {
    FR_IDLE,
    FR_CMD,
    FR_ADDR,
    FR_DATA,
    FR_IGNORE
  } fr_state_e;

  localparam logic [7:0] FR_READ_CMD  = 8'h03;
  localparam bit         FR_MSB_FIRST = 1'b1;
  localparam int         FR_CMD_BITS  = 8;
  localparam int         FR_ADDR_BITS = 24;

  // Little-endian byte lane select within a memory word.
  function automatic logic [7:0] fr_word_byte(input logic [31:0] word, input logic [1:0] idx);
    return word[8*idx +: 8];
  endfunction

  // Returns {bit to drive, remaining byte} for one serial shift step.
  function automatic logic [8:0] fr_shift_out(input logic [7:0] b);
    if (FR_MSB_FIRST) begin
      return {b[7], b[6:0], 1'b0};
    end
    return {b[0], 1'b0, b[7:1]};
  endfunction

endpackage

// File: rtl/spi_flash_responder_pin_sync.sv
// rtl/spi_flash_responder_pin_sync.sv - SPI pin synchronizers with spi_clk rise/fall pulses
module spi_pin_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic spi_clk_i,
  input  logic spi_cs_i,
  input  logic spi_mosi_i,
  output logic cs_n_o,
  output logic mosi_o,
  output logic sclk_rise_o,
  output logic sclk_fall_o
);

  logic [SYNC_STAGES-1:0] clk_sync_q;
  logic [SYNC_STAGES-1:0] cs_sync_q;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic                   sclk_prev_q;
  logic                   sclk_s;

  assign sclk_s = clk_sync_q[SYNC_STAGES-1];

  // Chip-select resets to its released level so the responder starts deselected.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
    end else begin
      clk_sync_q  <= (clk_sync_q << 1) | SYNC_STAGES'(spi_clk_i);
      cs_sync_q   <= (cs_sync_q << 1) | SYNC_STAGES'(spi_cs_i);
      mosi_sync_q <= (mosi_sync_q << 1) | SYNC_STAGES'(spi_mosi_i);
      sclk_prev_q <= sclk_s;
    end
  end

  assign cs_n_o      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_o      = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise_o = sclk_s & ~sclk_prev_q;
  assign sclk_fall_o = ~sclk_s & sclk_prev_q;

endmodule

// File: rtl/spi_flash_responder.sv
// rtl/spi_flash_responder.sv - read-only SPI flash responder streaming bytes from word memory
module spi_flash_responder
  import spi_flash_responder_pkg::*;
#(
  parameter int         ADDR_W      = 24,
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] READ_CMD    = FR_READ_CMD
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_clk,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_ren,
  output logic [ADDR_W-3:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              busy,
  output logic              cmd_err
);

  localparam int WA = ADDR_W - 2;

  fr_state_e         state_q, state_d;
  logic [4:0]        bit_cnt_q, bit_cnt_d;
  logic [23:0]       shift_q, shift_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       word_q, word_d;
  logic [7:0]        byte_q, byte_d;
  logic              miso_q, miso_d;
  logic              ren_q, ren_d;
  logic [WA-1:0]     maddr_q, maddr_d;
  logic              err_q, err_d;
  logic              first_q, first_d;
  logic              rvalid_q;

  logic              cs_n_s, mosi_s, sclk_rise, sclk_fall;
  logic [23:0]       shift_in;
  logic [ADDR_W-1:0] addr_next;
  logic [8:0]        shout;

  spi_pin_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_pin_sync (
    .clk        (clk),
    .reset      (reset),
    .spi_clk_i  (spi_clk),
    .spi_cs_i   (spi_cs),
    .spi_mosi_i (spi_mosi),
    .cs_n_o     (cs_n_s),
    .mosi_o     (mosi_s),
    .sclk_rise_o(sclk_rise),
    .sclk_fall_o(sclk_fall)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    addr_d    = addr_q;
    word_d    = word_q;
    byte_d    = byte_q;
    miso_d    = miso_q;
    ren_d     = 1'b0;
    maddr_d   = maddr_q;
    err_d     = 1'b0;
    first_d   = first_q;
    shift_in  = {shift_q[22:0], mosi_s};
    addr_next = addr_q + ADDR_W'(1);
    shout     = fr_shift_out(byte_q);

    // CS release wins over everything: partial bytes and late read data are dropped.
    if (state_q != FR_IDLE && cs_n_s) begin
      state_d = FR_IDLE;
    end else begin
      unique case (state_q)
        FR_IDLE: begin
          if (!cs_n_s) begin
            state_d   = FR_CMD;
            bit_cnt_d = '0;
            shift_d   = '0;
          end
        end
        FR_CMD: begin
          if (sclk_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'(FR_CMD_BITS - 1)) begin
              bit_cnt_d = '0;
              if (shift_in[7:0] == READ_CMD) begin
                state_d = FR_ADDR;
              end else begin
                err_d   = 1'b1;
                state_d = FR_IGNORE;
              end
            end
          end
        end
        FR_ADDR: begin
          if (sclk_rise) begin
            shift_d   = shift_in;
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'(FR_ADDR_BITS - 1)) begin
              bit_cnt_d = '0;
              addr_d    = shift_in[ADDR_W-1:0];
              ren_d     = 1'b1;
              maddr_d   = shift_in[ADDR_W-1:2];
              first_d   = 1'b1;
              state_d   = FR_DATA;
            end
          end
        end
        FR_DATA: begin
          // The first returned word also seeds the shift byte; later ones only refill the buffer.
          if (rvalid_q) begin
            word_d = mem_rdata;
            if (first_q) begin
              first_d = 1'b0;
              byte_d  = fr_word_byte(mem_rdata, addr_q[1:0]);
              if (addr_q[1:0] == 2'd3) begin
                ren_d   = 1'b1;
                maddr_d = addr_q[ADDR_W-1:2] + WA'(1);
              end
            end
          end
          if (sclk_fall) begin
            miso_d    = shout[8];
            byte_d    = shout[7:0];
            bit_cnt_d = bit_cnt_q + 5'd1;
            if (bit_cnt_q == 5'd7) begin
              bit_cnt_d = '0;
              addr_d    = addr_next;
              byte_d    = fr_word_byte(word_q, addr_next[1:0]);
              if (addr_next[1:0] == 2'd3) begin
                ren_d   = 1'b1;
                maddr_d = addr_next[ADDR_W-1:2] + WA'(1);
              end
            end
          end
        end
        FR_IGNORE: begin
          state_d = FR_IGNORE;
        end
        default: begin
          state_d = FR_IDLE;
        end
      endcase
    end

    if (state_d != FR_DATA) begin
      miso_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FR_IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      addr_q    <= '0;
      word_q    <= '0;
      byte_q    <= '0;
      miso_q    <= 1'b0;
      ren_q     <= 1'b0;
      maddr_q   <= '0;
      err_q     <= 1'b0;
      first_q   <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      addr_q    <= addr_d;
      word_q    <= word_d;
      byte_q    <= byte_d;
      miso_q    <= miso_d;
      ren_q     <= ren_d;
      maddr_q   <= maddr_d;
      err_q     <= err_d;
      first_q   <= first_d;
      rvalid_q  <= ren_q;
    end
  end

  assign spi_miso = miso_q;
  assign mem_ren  = ren_q;
  assign mem_addr = maddr_q;
  assign busy     = ~cs_n_s;
  assign cmd_err  = err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// tb/tb_spi_flash_responder.sv - self-checking bench for spi_flash_responder
module tb_spi_flash_responder;

  localparam int SYNC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_clk, spi_cs, spi_mosi, spi_miso;
  logic        mem_ren, busy, cmd_err;
  logic [21:0] mem_addr;
  logic [31:0] mem_rdata;

  int          checks = 0;
  int          errors = 0;
  int          err_pulses = 0;
  bit          zero_chk = 1'b0;
  logic [21:0] exp_ren_q[$];
  logic [21:0] ren_log[$];
  logic [31:0] mem_ov[logic [21:0]];

  always #5 clk = ~clk;

  spi_flash_responder dut (
    .clk      (clk),
    .reset    (reset),
    .spi_clk  (spi_clk),
    .spi_cs   (spi_cs),
    .spi_mosi (spi_mosi),
    .spi_miso (spi_miso),
    .mem_ren  (mem_ren),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .cmd_err  (cmd_err)
  );

  function automatic logic [31:0] mem_word(input logic [21:0] w);
    if (mem_ov.exists(w)) return mem_ov[w];
    return ({10'b0, w} * 32'h9E37_79B1) ^ 32'h5A3C_96E1;
  endfunction

  function automatic logic [7:0] exp_byte(input logic [23:0] ba);
    logic [31:0] wd;
    wd = mem_word(ba[23:2]);
    return wd[8*ba[1:0] +: 8];
  endfunction

  function automatic logic [21:0] log_at(input int i);
    if (i < ren_log.size()) return ren_log[i];
    return 22'h2AAAAA;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  // Memory answers exactly one cycle after the read strobe.
  always @(posedge clk) begin
    if (mem_ren) mem_rdata <= mem_word(mem_addr);
  end

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_ren) begin
        ren_log.push_back(mem_addr);
        chk("mem_ren_expected", 64'(mem_ren), 64'(exp_ren_q.size() != 0));
        if (exp_ren_q.size() != 0) chk("mem_addr", 64'(mem_addr), 64'(exp_ren_q.pop_front()));
      end
      if (cmd_err) err_pulses++;
      if (zero_chk) chk("miso_quiet", 64'(spi_miso), 64'd0);
    end
  end

  task automatic run_frame(input logic [7:0] op, input logic [23:0] a, input int nb,
                           input int cut, output logic [47:0] got);
    int          hp, nclk, bcnt, wait_cnt, n_exp;
    bit          good;
    logic [31:0] hdr;
    logic [23:0] b;
    logic [21:0] w;
    logic [7:0]  eb;
    hdr  = {op, a};
    good = (op == 8'h03) && (cut == 0);
    nclk = (cut != 0) ? cut : 32 + 8*nb;
    hp   = $urandom_range(5, 9);
    got  = '0;
    exp_ren_q.delete();
    ren_log.delete();
    err_pulses = 0;
    // Bytes 0..nb get loaded; each loaded byte at offset 3 in its word prefetches the next word.
    if (good) begin
      exp_ren_q.push_back(a[23:2]);
      for (int k = 0; k <= nb; k++) begin
        b = a + 24'(k);
        if (b[1:0] == 2'd3) begin
          w = b[23:2] + 22'd1;
          exp_ren_q.push_back(w);
        end
      end
    end
    n_exp    = exp_ren_q.size();
    zero_chk = 1'b1;
    spi_cs   = 1'b0;
    repeat (hp) @(negedge clk);
    chk("busy_in_frame", 64'(busy), 64'd1);
    for (int c = 0; c < nclk; c++) begin
      spi_mosi = (c < 32) ? hdr[31-c] : 1'($urandom);
      repeat (hp) @(negedge clk);
      if (c >= 32 && good) begin
        bcnt = c - 32;
        eb   = exp_byte(a + 24'(bcnt / 8));
        got  = {got[46:0], spi_miso};
        chk("miso_bit", 64'(spi_miso), 64'(eb[7 - (bcnt % 8)]));
      end
      spi_clk = 1'b1;
      repeat (hp) @(negedge clk);
      if (c == 31 && good) zero_chk = 1'b0;
      spi_clk = 1'b0;
    end
    repeat (hp) @(negedge clk);
    spi_cs   = 1'b1;
    wait_cnt = 0;
    while (busy && wait_cnt < 20) begin
      @(negedge clk);
      wait_cnt++;
    end
    chk("busy_release_latency", 64'(wait_cnt <= SYNC + 1), 64'd1);
    repeat (4) @(negedge clk);
    zero_chk = 1'b1;
    chk("mem_ren_count", 64'(ren_log.size()), 64'(n_exp));
    chk("cmd_err_pulses", 64'(err_pulses), 64'((op != 8'h03 && (cut == 0 || cut >= 8)) ? 1 : 0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [47:0] got;
    logic [7:0]  op;
    int          cut;
    reset    = 1'b1;
    spi_clk  = 1'b0;
    spi_cs   = 1'b1;
    spi_mosi = 1'b0;
    mem_ov[22'h000001] = 32'h44332211;
    mem_ov[22'h000002] = 32'h88776655;
    mem_ov[22'h3FFFFF] = 32'hDDCCBBAA;
    mem_ov[22'h000000] = 32'h04030201;

    repeat (3) @(negedge clk);
    chk("rst_miso", 64'(spi_miso), 64'd0);
    chk("rst_mem_ren", 64'(mem_ren), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cmd_err", 64'(cmd_err), 64'd0);
    reset = 1'b0;
    zero_chk = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_ren_log", 64'(ren_log.size()), 64'd0);

    run_frame(8'h03, 24'h000004, 4, 0, got);
    chk("aligned_bytes", 64'(got[31:0]), 64'h11223344);
    chk("aligned_ren_n", 64'(ren_log.size()), 64'd2);
    chk("aligned_ren0", 64'(log_at(0)), 64'h1);
    chk("aligned_ren1", 64'(log_at(1)), 64'h2);

    run_frame(8'h03, 24'h000006, 4, 0, got);
    chk("unaligned_bytes", 64'(got[31:0]), 64'h33445566);
    chk("unaligned_ren0", 64'(log_at(0)), 64'h1);
    chk("unaligned_ren1", 64'(log_at(1)), 64'h2);

    run_frame(8'h0B, 24'h000004, 4, 0, got);
    chk("badop_err_pulses", 64'(err_pulses), 64'd1);
    chk("badop_no_ren", 64'(ren_log.size()), 64'd0);

    run_frame(8'h03, 24'h000010, 4, 20, got);
    chk("early_no_ren", 64'(ren_log.size()), 64'd0);
    run_frame(8'h03, 24'h000000, 4, 0, got);
    chk("after_early_bytes", 64'(got[31:0]), 64'h01020304);
    chk("after_early_ren0", 64'(log_at(0)), 64'h0);
    chk("after_early_ren1", 64'(log_at(1)), 64'h1);

    run_frame(8'h03, 24'hFFFFFE, 4, 0, got);
    chk("wrap_bytes", 64'(got[31:0]), 64'hCCDD0102);
    chk("wrap_ren0", 64'(log_at(0)), 64'h3FFFFF);
    chk("wrap_ren1", 64'(log_at(1)), 64'h0);

    for (int i = 0; i < 16; i++) begin
      op  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'h03;
      cut = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 31)) : 0;
      run_frame(op, 24'($urandom), int'($urandom_range(1, 6)), cut, got);
      repeat ($urandom_range(2, 10)) @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
